// File: rtl/fc_pkg.sv
// fc_pkg: shared types and sizing helpers for the fully connected parameter loader.
package fc_pkg;
    localparam int FC_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, ERR} fc_ld_state_t;

    function automatic int cnt_w(input int m, input int n);
        return $clog2(m * n + m + 1);
    endfunction
endpackage

// File: rtl/fc_param_bank.sv
// fc_param_bank: flat weight/bias register array written one element at a time.
// FC_LOADER_SHADOW_EN adds a shadow bank that is copied to the active bank on commit.
module fc_param_bank import fc_pkg::*; #(
    parameter int M      = 4,
    parameter int N      = 8,
    parameter int DATA_W = FC_DATA_W,
    parameter int AW     = cnt_w(M, N)
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef FC_LOADER_SHADOW_EN
    input  logic                       commit,
`endif
    input  logic                       we,
    input  logic [AW-1:0]              addr,
    input  logic [DATA_W-1:0]          data,
    output logic [M*N*DATA_W-1:0]      weights_flat,
    output logic [M*DATA_W-1:0]        biases_flat
);
    localparam int BW = (M * N + M) * DATA_W;

    logic [BW-1:0] active;

`ifdef FC_LOADER_SHADOW_EN
    logic [BW-1:0] shadow, shadow_next;

    // The commit edge also carries the final bias, so copy the updated shadow.
    always_comb begin
        shadow_next = shadow;
        if (we)
            shadow_next[int'(addr) * DATA_W +: DATA_W] = data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= '0;
            shadow <= '0;
        end else begin
            shadow <= shadow_next;
            if (commit)
                active <= shadow_next;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n)
            active <= '0;
        else if (we)
            active[int'(addr) * DATA_W +: DATA_W] <= data;
    end
`endif

    assign weights_flat = active[M*N*DATA_W-1:0];
    assign biases_flat  = active[BW-1 -: M*DATA_W];
endmodule

// File: rtl/fc_param_loader.sv
// fc_param_loader: streams weights then biases into a register bank with frame-length checking.
// FC_LOADER_SHADOW_EN keeps the last committed set visible while a new frame loads.
module fc_param_loader import fc_pkg::*; #(
    parameter int M      = 4,
    parameter int N      = 8,
    parameter int DATA_W = FC_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_last,
    output logic [M*N*DATA_W-1:0]      weights_flat,
    output logic [M*DATA_W-1:0]        biases_flat,
    output logic                       params_valid,
    output logic                       busy,
    output logic                       err
);
    localparam int TOTAL = M * N + M;
    localparam int CW    = cnt_w(M, N);
`ifdef FC_LOADER_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    fc_ld_state_t  state;
    logic [CW-1:0] cnt;
    logic          accept, last_el, frame_ok;

    assign accept   = s_valid && s_ready;
    assign last_el  = cnt == CW'(TOTAL - 1);
    assign frame_ok = accept && (s_last == last_el);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            s_ready      <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            params_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ERR: if (start) begin
                    state        <= LOAD_W;
                    cnt          <= '0;
                    s_ready      <= 1'b1;
                    busy         <= 1'b1;
                    err          <= 1'b0;
                    params_valid <= SHADOW && params_valid;
                end
                LOAD_W, LOAD_B: if (accept) begin
                    if (s_last != last_el) begin
                        state   <= ERR;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else if (last_el) begin
                        state        <= IDLE;
                        s_ready      <= 1'b0;
                        busy         <= 1'b0;
                        params_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(M * N - 1))
                            state <= LOAD_B;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fc_param_bank #(.M(M), .N(N), .DATA_W(DATA_W), .AW(CW)) u_bank (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef FC_LOADER_SHADOW_EN
        .commit       (frame_ok && last_el),
`endif
        .we           (frame_ok),
        .addr         (cnt),
        .data         (s_data),
        .weights_flat (weights_flat),
        .biases_flat  (biases_flat)
    );
endmodule
